fir_error_stats: RTL and testbench
==================================

Name: fir_error_stats

Overview:
- Sits directly downstream of the 6-tap approximate FIR datapath. It consumes each approximate output sample together with the exact-FIR output for the same sample.
- Accumulates the error e = approx - exact over a window of 2^LOG2_N samples. At window end it emits the mean error, the error variance and the max |error|.
- These numbers are the measured error statistics that the approximate-unit selection flow compares against its variance budget.

Parameters:
- DATA_W, 16, width of the signed FIR output samples (approx and exact).
- LOG2_N, 4, log2 of the window length N (default N = 16 samples).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  approx_in/exact_in pair is valid.
- in_ready  output  1  block accepts a sample pair this cycle.
- approx_in  input  DATA_W  signed approximate FIR output (out_11 of the datapath).
- exact_in  input  DATA_W  signed exact FIR output for the same sample.
- out_valid  output  1  statistics are valid.
- out_ready  input  1  consumer accepts the statistics.
- mean_err  output  DATA_W+1  signed, floor(sum_e / N).
- var_err  output  2*(DATA_W+1)  unsigned, max(0, floor(sum_e2 / N) - mean_err^2).
- max_abs_err  output  DATA_W+1  unsigned, max |e| over the window.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM; sample counter, sum, sumsq and max cleared.
  - out_valid=0, mean_err=0, var_err=0, max_abs_err=0, in_ready=1 after reset release.
- Error arithmetic:
  - e = sign-extend(approx_in) - sign-extend(exact_in), DATA_W+1 bits signed. This never overflows; extremes are +65535 / -65535 at DATA_W=16.
  - sum: signed, DATA_W+1+LOG2_N bits.
  - sumsq: unsigned, 2*(DATA_W+1)+LOG2_N bits; e*e is computed exactly.
  - |e| is exact in DATA_W+1 bits unsigned.
- Handshake: a sample transfers when in_valid && in_ready; an output transfers when out_valid && out_ready.
- in_ready=1 only in ACCUM. in_valid while in_ready=0 is ignored, and the source must hold it.
- FSM ACCUM:
  - On each transfer, update sum, sumsq and max, then increment the counter.
  - On the N-th transfer (counter == N-1), go to MEAN next cycle. The counter wraps to 0 and the accumulators hold their final values.
- FSM MEAN (1 cycle):
  - mean_reg = sum >>> LOG2_N (arithmetic shift, floors toward -inf).
  - msq_reg = sumsq >> LOG2_N.
  - Go to VAR.
- FSM VAR (1 cycle):
  - d = msq_reg - mean_reg*mean_reg, computed signed with one guard bit.
  - var_err = 0 if d<0 (possible from floor truncation of mean), else d truncated to 2*(DATA_W+1) bits. The truncation never drops nonzero bits, since d ≤ max e^2.
  - Load the mean_err, var_err and max_abs_err outputs; out_valid=1; go to HOLD.
- FSM HOLD:
  - Outputs are stable while out_valid && !out_ready.
  - On an out_ready handshake: out_valid=0, accumulators cleared, state=ACCUM (in_ready=1 the following cycle).
- Latency: the N-th input handshake is at cycle T; out_valid rises at cycle T+3. Minimum window-to-window turnaround is N+3 cycles with out_ready tied high.
- Output registers retain their last values after the handshake until the next VAR overwrites them.
- Reset mid-window or mid-HOLD: the partial window is discarded, out_valid drops immediately (async), and accumulation restarts from zero.
- Gaps in in_valid are allowed; the window counts transfers, not cycles.

Test Plan:
- 16 pairs approx=exact (random values) -> mean_err=0, var_err=0, max_abs_err=0; out_valid 3 cycles after the 16th transfer.
- 16 pairs with e=+3 (e.g. approx=100, exact=97) -> mean_err=3, var_err=0, max_abs_err=3.
- Alternating e=+2/-2 for 16 samples -> mean_err=0, var_err=4, max_abs_err=2.
- Alternating e=-1/0 -> sum=-8, mean_err=-1, msq=0, d=-1 -> var_err clamped to 0, max_abs_err=1.
- Extreme values: approx=32767, exact=-32768 for all 16 samples -> mean_err=65535, var_err=0, max_abs_err=65535; no overflow.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> in_ready stays 0, outputs stable, inputs ignored. Release -> one handshake, next window starts clean.
  - Assert rst_n=0 after 7 samples -> 16 fresh samples of e=+3 still yield mean_err=3.

Source files
------------

// File: rtl/fir_error_stats.sv
// fir_error_stats: windowed error statistics (mean, variance, max |e|)
// between the approximate and exact FIR outputs over 2^LOG2_N samples.
module fir_error_stats #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         approx_in,
    input  logic [DATA_W-1:0]         exact_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W:0]           mean_err,
    output logic [2*(DATA_W+1)-1:0]   var_err,
    output logic [DATA_W:0]           max_abs_err
);

    localparam int unsigned EW = DATA_W + 1;        // error width
    localparam int unsigned SW = EW + LOG2_N;       // sum width
    localparam int unsigned VW = 2 * EW;            // square / variance width
    localparam int unsigned QW = VW + LOG2_N;       // sum of squares width
    localparam int unsigned N  = 1 << LOG2_N;

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] MEAN  = 2'd1;
    localparam logic [1:0] VAR   = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [LOG2_N-1:0]      cnt_q, cnt_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic [QW-1:0]          sumsq_q, sumsq_d;
    logic [EW-1:0]          max_q, max_d;
    logic signed [EW-1:0]   mean_q, mean_d;
    logic [VW-1:0]          msq_q, msq_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [EW-1:0]   mean_err_q, mean_err_d;
    logic [VW-1:0]          var_err_q, var_err_d;
    logic [EW-1:0]          max_abs_err_q, max_abs_err_d;

    logic signed [EW-1:0]   err_c;
    logic signed [VW-1:0]   sq_c;
    logic [EW-1:0]          abs_c;
    logic signed [VW-1:0]   prod_c;
    logic signed [VW:0]     diff_c;
    logic                   take_c;

    // Per-sample error terms; one extra bit keeps the difference exact.
    always_comb begin
        err_c  = $signed({approx_in[DATA_W-1], approx_in}) - $signed({exact_in[DATA_W-1], exact_in});
        sq_c   = err_c * err_c;
        abs_c  = err_c[EW-1] ? $unsigned(-err_c) : $unsigned(err_c);
        prod_c = mean_q * mean_q;
        diff_c = $signed({1'b0, msq_q}) - $signed({prod_c[VW-1], prod_c});
        take_c = in_valid && in_ready_q;
    end

    // Next-state and datapath update for the ACCUM/MEAN/VAR/HOLD sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        sumsq_d       = sumsq_q;
        max_d         = max_q;
        mean_d        = mean_q;
        msq_d         = msq_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        mean_err_d    = mean_err_q;
        var_err_d     = var_err_q;
        max_abs_err_d = max_abs_err_q;

        case (state_q)
            ACCUM: begin
                if (take_c) begin
                    sum_d   = sum_q + SW'(err_c);
                    sumsq_d = sumsq_q + QW'($unsigned(sq_c));
                    if (abs_c > max_q) begin
                        max_d = abs_c;
                    end
                    cnt_d = cnt_q + LOG2_N'(1);
                    if (cnt_q == LOG2_N'(N - 1)) begin
                        state_d    = MEAN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            MEAN: begin
                mean_d  = EW'(sum_q >>> LOG2_N);
                msq_d   = VW'(sumsq_q >> LOG2_N);
                state_d = VAR;
            end
            VAR: begin
                mean_err_d    = mean_q;
                var_err_d     = diff_c[VW] ? '0 : diff_c[VW-1:0];
                max_abs_err_d = max_q;
                out_valid_d   = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sum_d       = '0;
                    sumsq_d     = '0;
                    max_d       = '0;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d    = ACCUM;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            cnt_q         <= '0;
            sum_q         <= '0;
            sumsq_q       <= '0;
            max_q         <= '0;
            mean_q        <= '0;
            msq_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            mean_err_q    <= '0;
            var_err_q     <= '0;
            max_abs_err_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            sumsq_q       <= sumsq_d;
            max_q         <= max_d;
            mean_q        <= mean_d;
            msq_q         <= msq_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            mean_err_q    <= mean_err_d;
            var_err_q     <= var_err_d;
            max_abs_err_q <= max_abs_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign mean_err    = mean_err_q;
    assign var_err     = var_err_q;
    assign max_abs_err = max_abs_err_q;

endmodule

// File: tb/tb_fir_error_stats.sv
// Scoreboard bench for fir_error_stats with a window-level statistics model.
module tb_fir_error_stats;

    localparam int P = 10;
    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] approx_in = '0;
    logic [15:0] exact_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] mean_err;
    logic [33:0] var_err;
    logic [16:0] max_abs_err;

    fir_error_stats #(.DATA_W(16), .LOG2_N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .approx_in(approx_in), .exact_in(exact_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mean_err(mean_err), .var_err(var_err), .max_abs_err(max_abs_err)
    );

    always #(P/2) clk = ~clk;

    typedef struct {
        longint mean;
        longint vr;
        longint mx;
    } exp_t;

    exp_t   sb[$];
    int     errq[$];
    int     total = 0;
    int     bad = 0;
    longint exp_rise = 0;
    bit     prev_ov = 1'b0;
    bit     rand_rdy = 1'b0;
    bit     rdy_fixed = 1'b1;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: statistics of one complete window from the list of errors.
    function automatic exp_t window_stats();
        exp_t   r;
        longint s = 0, s2 = 0, mx = 0, msq, m, v;
        foreach (errq[i]) begin
            s  += errq[i];
            s2 += longint'(errq[i]) * longint'(errq[i]);
            if ((errq[i] < 0 ? -errq[i] : errq[i]) > mx) mx = (errq[i] < 0 ? -errq[i] : errq[i]);
        end
        m = s / NS;
        if ((s % NS) != 0 && s < 0) m = m - 1;
        msq = s2 / NS;
        v = msq - m * m;
        if (v < 0) v = 0;
        r.mean = m;
        r.vr   = v;
        r.mx   = mx;
        return r;
    endfunction

    // Output-ready driver (single writer of out_ready).
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: latency of each rising out_valid and scoreboard comparison per handshake.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) chk("latency", longint'($time), exp_rise);
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mean_err", longint'($signed(mean_err)), e.mean);
                chk("var_err", longint'(var_err), e.vr);
                chk("max_abs_err", longint'(max_abs_err), e.mx);
            end
        end
    end

    // Present one pair until accepted; called and returns at posedge+1.
    task automatic send(input logic [15:0] a, input logic [15:0] x);
        bit done = 1'b0;
        int guard = 0;
        in_valid  = 1'b1;
        approx_in = a;
        exact_in  = x;
        while (!done && guard < 300) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!done) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            errq.push_back(int'($signed(a)) - int'($signed(x)));
            if (errq.size() == NS) begin
                sb.push_back(window_stats());
                exp_rise = longint'($time) - 1 + 2 * P + P / 2;
                errq.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", longint'(sb.size()), 0);
    endtask

    initial begin
        logic [15:0] a, x;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_mean", longint'(mean_err), 0);
        chk("rst_var", longint'(var_err), 0);
        chk("rst_max", longint'(max_abs_err), 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);

        // approx == exact
        for (int i = 0; i < NS; i++) begin
            a = 16'($urandom);
            send(a, a);
        end
        drain();
        // constant e = +3
        for (int i = 0; i < NS; i++) send(16'd100, 16'd97);
        drain();
        // alternating +2 / -2
        for (int i = 0; i < NS; i++) send(16'd1000, (i % 2 == 0) ? 16'd998 : 16'd1002);
        drain();
        // alternating -1 / 0: variance clamps to zero
        for (int i = 0; i < NS; i++) send(16'd500, (i % 2 == 0) ? 16'd501 : 16'd500);
        drain();
        // extreme operands
        for (int i = 0; i < NS; i++) send(16'h7fff, 16'h8000);
        drain();

        // backpressure: outputs held, inputs ignored
        rdy_fixed = 1'b0;
        for (int i = 0; i < NS; i++) begin
            x = 16'($urandom);
            send(x + 16'($urandom_range(0, 40)) - 16'd20, x);
        end
        begin
            int g = 0;
            while (!out_valid && g < 20) begin
                @(posedge clk);
                #1;
                g++;
            end
        end
        in_valid  = 1'b1;
        approx_in = 16'h1234;
        exact_in  = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            if (sb.size() == 1) begin
                chk("bp_mean_stable", longint'($signed(mean_err)), sb[0].mean);
                chk("bp_max_stable", longint'(max_abs_err), sb[0].mx);
            end else begin
                chk("bp_sb_depth", longint'(sb.size()), 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        rdy_fixed = 1'b1;
        drain();
        for (int i = 0; i < NS; i++) send(16'd100, 16'd97);
        drain();

        // reset after 7 samples
        for (int i = 0; i < 7; i++) send(16'($urandom), 16'($urandom));
        rst_n = 1'b0;
        errq.delete();
        #1;
        chk("midwin_rst_out_valid", longint'(out_valid), 0);
        chk("midwin_rst_mean", longint'(mean_err), 0);
        chk("midwin_rst_max", longint'(max_abs_err), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) send(16'd100, 16'd97);
        drain();

        // reset while holding output
        rdy_fixed = 1'b0;
        for (int i = 0; i < NS; i++) send(16'($urandom), 16'($urandom));
        begin
            int g = 0;
            while (!out_valid && g < 20) begin
                @(posedge clk);
                #1;
                g++;
            end
            chk("hold_reached", longint'(out_valid), 1);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("hold_rst_out_valid", longint'(out_valid), 0);
        #2 rst_n = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;

        // random windows with gaps and random backpressure
        rand_rdy = 1'b1;
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < NS; i++) begin
                x = 16'($urandom);
                if (w % 2 == 0) a = 16'($urandom);
                else a = x + 16'($urandom_range(0, 200)) - 16'd100;
                send(a, x);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        rand_rdy = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
